// File: rtl/st_add_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package st_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // Ceiling log2, floored at 1 so a single-nibble build still has an index bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/st_add_slice.sv
// Combinational 4-bit ripple-carry slice built from per-bit full adders.
module st_add_slice
  import st_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[NIBBLE_W];

endmodule

// File: rtl/st_add_seq.sv
// Nibble-serial wide adder: one shared 4-bit slice walked LSB nibble first.
// Optional macro SUB_EN adds a 'sub' port (a - b via a + ~b + 1).
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; s/co hold the last result
// RUN   | one nibble per cycle through the slice, carry registered
// DONE  | one-cycle result pulse; start here chains the next op
module st_add_seq
  import st_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        ci,
`ifdef SUB_EN
  input  logic                        sub,
`endif
  output logic [NIBBLE_W*NIBBLES-1:0] s,
  output logic                        co,
  output logic                        busy,
  output logic                        done
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t              state_q, state_d;
  logic [W-1:0]        a_q, b_q, s_q;
  logic                carry_q, co_q;
  logic [IW-1:0]       idx_q;
  logic                accept, sub_eff;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;

`ifdef SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign accept = start && (state_q != RUN);

  st_add_slice u_slice (
    .a  (a_q[NIBBLE_W*idx_q +: NIBBLE_W]),
    .b  (b_q[NIBBLE_W*idx_q +: NIBBLE_W]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is folded in at accept time: b is stored inverted and the carry seeded with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a;
        b_q     <= sub_eff ? ~b : b;
        carry_q <= sub_eff ? 1'b1 : ci;
        idx_q   <= '0;
        s_q     <= '0;
      end else if (state_q == RUN) begin
        s_q[NIBBLE_W*idx_q +: NIBBLE_W] <= slice_s;
        carry_q <= slice_co;
        idx_q   <= idx_q + 1'b1;
        if (idx_q == LAST_IDX) co_q <= slice_co;
      end
    end
  end

  assign s    = s_q;
  assign co   = co_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_st_add_seq.sv
// Scoreboard bench for st_add_seq: 4-nibble instance plus a 1-nibble instance.
module tb_st_add_seq;

  typedef struct {
    logic [15:0] s;
    logic        co;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, ci;
  logic [15:0] a, b, s;
  logic        co, busy, done;
`ifdef SUB_EN
  logic        sub;
`endif

  logic        start1, ci1;
  logic [3:0]  a1, b1, s1;
  logic        co1, busy1, done1;

  exp_t q[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   dones  = 0;

  always #5 clk = ~clk;

  st_add_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
`ifdef SUB_EN
    .sub(sub),
`endif
    .s(s), .co(co), .busy(busy), .done(done)
  );

  st_add_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .ci(ci1),
`ifdef SUB_EN
    .sub(1'b0),
`endif
    .s(s1), .co(co1), .busy(busy1), .done(done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one start cycle; returns at the negedge inside RUN cycle 1.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic civ,
                       input logic subv, input logic push,
                       input logic [15:0] es, input logic eco);
    @(negedge clk);
    a = av; b = bv; ci = civ; start = 1'b1;
`ifdef SUB_EN
    sub = subv;
`else
    if (subv) $display("note: sub requested without SUB_EN");
`endif
    if (push) q.push_back('{es, eco});
    @(negedge clk);
    start = 1'b0;
`ifdef SUB_EN
    sub = 1'b0;
`endif
  endtask

  // Counts busy cycles until done; returns at the negedge where done is high.
  task automatic measure(input string name, input int exp_busy);
    int nb;
    int t;
    nb = 0;
    t  = 0;
    while (!done && t < 30) begin
      if (busy) nb++;
      @(negedge clk);
      t++;
    end
    check({name, " done_timeout"}, 32'(t < 30), 32'd1);
    check({name, " busy_cycles"}, 32'(nb), 32'(exp_busy));
  endtask

  task automatic finish_op(input string name);
    @(negedge clk);
    check({name, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic stimulus();
    int t;
    int d0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
`ifdef SUB_EN
    sub = 1'b0;
`endif
    #1;
    check("reset s", 32'(s), 32'h0);
    check("reset co", 32'(co), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0);
    measure("basic", 4);
    finish_op("basic");

    issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1);
    measure("ripple", 4);
    finish_op("ripple");
    check("ripple hold s", 32'(s), 32'h0000);
    check("ripple hold co", 32'(co), 32'h1);

    issue(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, 16'h5556, 1'b0);
    measure("mixed", 4);
    finish_op("mixed");

    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    measure("allones", 4);
    finish_op("allones");

    // start while busy must be ignored
    d0 = dones;
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h2345, 1'b0);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_start done_count", 32'(dones - d0), 32'd1);

    // reset mid-operation
    d0 = dones;
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst s", 32'(s), 32'h0);
    check("midrst co", 32'(co), 32'h0);
    check("midrst busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst no_done", 32'(dones - d0), 32'd0);
    check("midrst s_after", 32'(s), 32'h0);
    issue(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0);
    measure("after_rst", 4);
    finish_op("after_rst");

    // back-to-back: start during DONE
    issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0);
    measure("b2b_first", 4);
    a = 16'h7FFF; b = 16'h0001; ci = 1'b0; start = 1'b1;
    q.push_back('{16'h8000, 1'b0});
    @(negedge clk);
    start = 1'b0;
    check("b2b busy_after_done", 32'(busy), 32'd1);
    t = 1;
    while (!done && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("b2b done_spacing", 32'(t), 32'd5);
    finish_op("b2b_second");

`ifdef SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    measure("sub_neg", 4);
    finish_op("sub_neg");
    issue(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b1);
    measure("sub_pos", 4);
    finish_op("sub_pos");
`endif

    // single-nibble instance
    @(negedge clk);
    a1 = 4'hF; b1 = 4'h1; ci1 = 1'b0; start1 = 1'b1;
    q1.push_back('{16'h0000, 1'b1});
    @(negedge clk);
    start1 = 1'b0;
    check("n1 busy", 32'(busy1), 32'd1);
    check("n1 done_early", 32'(done1), 32'd0);
    @(negedge clk);
    check("n1 done", 32'(done1), 32'd1);
    check("n1 busy_off", 32'(busy1), 32'd0);
    @(negedge clk);
    check("n1 done_one_cycle", 32'(done1), 32'd0);

    repeat (3) @(negedge clk);
    check("queue drained", 32'(q.size()), 32'd0);
    check("queue1 drained", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    fork
      begin
        forever begin
          exp_t e;
          @(negedge clk);
          if (done) begin
            dones++;
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: got s=%0h co=%0h expected no done", s, co);
            end else begin
              e = q.pop_front();
              check("result s", 32'(s), 32'(e.s));
              check("result co", 32'(co), 32'(e.co));
            end
          end
          if (done1) begin
            if (q1.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done1: got s=%0h co=%0h expected no done", s1, co1);
            end else begin
              e = q1.pop_front();
              check("n1 result s", 32'(s1), 32'(e.s[3:0]));
              check("n1 result co", 32'(co1), 32'(e.co));
            end
          end
        end
      end
      begin
        stimulus();
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
